// File: rtl/door_plant_model.sv
// door_plant_model
// Cycle-based model of a sliding door driven by a door controller FSM.
// Motor commands are integrated into a door position, and the model
// produces the limit-switch feedback that the controller samples.
// Obstruction and command-conflict fault behaviour are modelled.
//
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset (priority over ena)
//   ena      - global enable; when low every register holds
//   ma, mc   - open / close motor commands
//   obstruct - obstacle in doorway, blocks closing motion
//   la, lc   - fully-open / fully-closed limit switches
//   pos      - current door position, 0..TRAVEL_TICKS
//   moving   - door is opening or closing
//   stall    - motor commanded in IDLE but no motion is possible
//   fault    - sticky: ma and mc were seen high together
module door_plant_model #(
    parameter int unsigned TRAVEL_TICKS = 16,
    parameter int unsigned PRESCALE     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       ma,
    input  logic       mc,
    input  logic       obstruct,
    output logic       la,
    output logic       lc,
    output logic [7:0] pos,
    output logic       moving,
    output logic       stall,
    output logic       fault
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPENING = 2'd1,
        ST_CLOSING = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    localparam logic [7:0]  TRAVEL_C     = 8'(TRAVEL_TICKS);
    localparam logic [15:0] PRESC_LAST_C = 16'(PRESCALE - 1);

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  pos_r;
    logic [7:0]  pos_s;
    logic [15:0] presc_r;
    logic [15:0] presc_s;
    logic        fault_r;
    logic        fault_s;
    logic        step_s;
    logic        la_s;
    logic        lc_s;

    // Limit switch decode straight from the position register
    always_comb begin
        la_s = (pos_r == TRAVEL_C);
        lc_s = (pos_r == 8'd0);
    end

    // Next-state, position and prescaler logic
    always_comb begin
        state_s = state_r;
        pos_s   = pos_r;
        presc_s = presc_r;
        step_s  = (presc_r == PRESC_LAST_C);
        case (state_r)
            ST_IDLE: begin
                presc_s = 16'd0;
                if (ma && mc) begin
                    state_s = ST_FAULT;
                end else if (ma && !la_s) begin
                    state_s = ST_OPENING;
                end else if (mc && !lc_s && !obstruct) begin
                    state_s = ST_CLOSING;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OPENING: begin
                if (ma && mc) begin
                    state_s = ST_FAULT;
                end else if (!ma) begin
                    state_s = ST_IDLE;
                end else if (step_s) begin
                    pos_s   = pos_r + 8'd1;
                    presc_s = 16'd0;
                    if (pos_r + 8'd1 == TRAVEL_C) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_OPENING;
                    end
                end else begin
                    presc_s = presc_r + 16'd1;
                end
            end
            ST_CLOSING: begin
                // Obstruct wins over a step that falls on the same edge
                if (ma && mc) begin
                    state_s = ST_FAULT;
                end else if (!mc || obstruct) begin
                    state_s = ST_IDLE;
                end else if (step_s) begin
                    pos_s   = pos_r - 8'd1;
                    presc_s = 16'd0;
                    if (pos_r == 8'd1) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_CLOSING;
                    end
                end else begin
                    presc_s = presc_r + 16'd1;
                end
            end
            ST_FAULT: begin
                state_s = ST_FAULT;
                presc_s = 16'd0;
            end
            default: begin
                state_s = ST_IDLE;
                presc_s = 16'd0;
            end
        endcase
        // Any state change restarts the step timing
        if (state_s != state_r) begin
            presc_s = 16'd0;
        end else begin
            presc_s = presc_s;
        end
        fault_s = fault_r | (state_s == ST_FAULT);
    end

    // State, position, prescaler and fault registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            pos_r   <= 8'd0;
            presc_r <= 16'd0;
            fault_r <= 1'b0;
        end else if (ena) begin
            state_r <= state_s;
            pos_r   <= pos_s;
            presc_r <= presc_s;
            fault_r <= fault_s;
        end else begin
            state_r <= state_r;
            pos_r   <= pos_r;
            presc_r <= presc_r;
            fault_r <= fault_r;
        end
    end

    // Output decode; stall is only meaningful while idle
    always_comb begin
        la     = la_s;
        lc     = lc_s;
        pos    = pos_r;
        moving = (state_r == ST_OPENING) || (state_r == ST_CLOSING);
        fault  = fault_r;
        if (state_r == ST_IDLE) begin
            stall = (ma && !mc && la_s) || (mc && !ma && (lc_s || obstruct));
        end else begin
            stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_door_plant_model.sv
module tb_door_plant_model;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       ma;
    logic       mc;
    logic       obstruct;
    logic       la;
    logic       lc;
    logic [7:0] pos;
    logic       moving;
    logic       stall;
    logic       fault;
    logic       la1;
    logic       lc1;
    logic [7:0] pos1;
    logic       moving1;
    logic       stall1;
    logic       fault1;

    int checks_cnt;
    int fail_cnt;

    door_plant_model #(.TRAVEL_TICKS(4), .PRESCALE(2)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .ma(ma), .mc(mc), .obstruct(obstruct),
        .la(la), .lc(lc), .pos(pos), .moving(moving), .stall(stall), .fault(fault)
    );

    // Second instance with a prescale of one shares the same stimulus
    door_plant_model #(.TRAVEL_TICKS(4), .PRESCALE(1)) u_dut1 (
        .clk(clk), .rst(rst), .ena(ena), .ma(ma), .mc(mc), .obstruct(obstruct),
        .la(la1), .lc(lc1), .pos(pos1), .moving(moving1), .stall(stall1), .fault(fault1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks_cnt++;
        if (obs != exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ena_val);
        rst = 1'b1; ena = ena_val; ma = 1'b0; mc = 1'b0; obstruct = 1'b0;
        tick();
        rst = 1'b0; ena = 1'b1;
    endtask

    initial begin
        int n;
        int exp_pos;
        int ctrl_st;
        checks_cnt = 0;
        fail_cnt   = 0;
        rst = 1'b0; ena = 1'b1; ma = 1'b0; mc = 1'b0; obstruct = 1'b0;
        tick();
        do_reset(1'b1);

        // Reset state
        check_val("rst_pos", pos, 0);
        check_val("rst_lc", lc, 1);
        check_val("rst_la", la, 0);
        check_val("rst_moving", moving, 0);
        check_val("rst_stall", stall, 0);
        check_val("rst_fault", fault, 0);

        // Close command at the closed limit stalls
        mc = 1'b1;
        #1;
        check_val("stall_closed", stall, 1);
        tick();
        check_val("stay_closed_mov", moving, 0);
        mc = 1'b0;

        // Open from closed: steps on edges 3,5,7,9
        do_reset(1'b1);
        ma = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            exp_pos = (e - 1) / 2;
            if (exp_pos > 4) exp_pos = 4;
            check_val($sformatf("open_pos_e%0d", e), pos, exp_pos);
            check_val($sformatf("open_mov_e%0d", e), moving, (e <= 8) ? 1 : 0);
            check_val($sformatf("open_la_e%0d", e), la, (e >= 9) ? 1 : 0);
            check_val($sformatf("open_stall_e%0d", e), stall, (e >= 9) ? 1 : 0);
            check_val($sformatf("open_p1_pos_e%0d", e), pos1, (e - 1 > 4) ? 4 : e - 1);
        end

        // Close with obstruction at the 3->2 step
        ma = 1'b0; mc = 1'b1;
        tick();
        check_val("close_enter_mov", moving, 1);
        tick();
        tick();
        check_val("close_pos3", pos, 3);
        tick();
        obstruct = 1'b1;
        tick();
        check_val("obst_pos", pos, 3);
        check_val("obst_mov", moving, 0);
        check_val("obst_stall", stall, 1);
        obstruct = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (lc) begin
                n = i;
                break;
            end
        end
        check_val("resume_edges", n, 7);
        check_val("resume_pos", pos, 0);
        check_val("resume_mov", moving, 0);
        mc = 1'b0;

        // Command release and re-entry
        do_reset(1'b1);
        ma = 1'b1;
        repeat (5) tick();
        check_val("rel_pos2", pos, 2);
        ma = 1'b0;
        tick();
        check_val("rel_idle_mov", moving, 0);
        check_val("rel_idle_pos", pos, 2);
        ma = 1'b1;
        tick();
        check_val("reent_mov", moving, 1);
        tick();
        check_val("reent_pos_hold", pos, 2);
        tick();
        check_val("reent_step", pos, 3);

        // Enable gating in mid-travel, partial prescale kept
        do_reset(1'b1);
        ma = 1'b1;
        repeat (4) tick();
        ena = 1'b0;
        repeat (5) tick();
        check_val("ena_hold_pos", pos, 1);
        check_val("ena_hold_mov", moving, 1);
        ena = 1'b1;
        tick();
        check_val("ena_partial", pos, 2);
        n = 0;
        for (int i = 11; i <= 40; i++) begin
            tick();
            if (la) begin
                n = i;
                break;
            end
        end
        check_val("ena_total_edges", n, 14);
        ma = 1'b0;

        // Fault mid-opening at pos 2
        do_reset(1'b1);
        ma = 1'b1;
        repeat (5) tick();
        mc = 1'b1;
        tick();
        check_val("fault_set", fault, 1);
        check_val("fault_mov", moving, 0);
        mc = 1'b0;
        repeat (3) tick();
        check_val("fault_pos_ma", pos, 2);
        ma = 1'b0; mc = 1'b1;
        repeat (3) tick();
        check_val("fault_pos_mc", pos, 2);
        check_val("fault_sticky", fault, 1);
        // Reset wins even with enable low
        do_reset(1'b0);
        check_val("fault_rst_pos", pos, 0);
        check_val("fault_rst_flag", fault, 0);
        check_val("fault_rst_p1", fault1, 0);

        // Closed loop with a minimal controller: open on presence until la
        ctrl_st = 0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            ma = (ctrl_st == 0) && !la;
            tick();
            if (la && ctrl_st == 0) begin
                ctrl_st = 1;
                n = i;
            end
            if (ctrl_st == 1) break;
        end
        check_val("loop_edges", n, 9);
        ma = (ctrl_st == 0) && !la;
        tick();
        check_val("loop_ctrl_ma", ma, 0);
        check_val("loop_mov", moving, 0);
        check_val("loop_stall", stall, 0);
        check_val("loop_pos", pos, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/door_plant_model.md
# door_plant_model

Cycle-based model of the physical sliding door driven by the door controller FSM. It consumes the controller's motor commands (open motor, close motor), integrates them into a door position, and produces the limit-switch feedback (fully-open, fully-closed) that the controller samples. Obstruction and fault behaviour is included, so the controller can be exercised closed-loop on silicon or in simulation without external hardware.

## Interface
Parameters:
- `TRAVEL_TICKS`, default 16: position steps from fully closed to fully open; legal range 1..255.
- `PRESCALE`, default 4: clock cycles per position step while moving; legal range 1..65535.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  reset; one clock, synchronous, active-high.
- `ena`  input  1  global enable. When low, state, prescaler, position and flags all hold.
- `ma`  input  1  open-motor command from the controller.
- `mc`  input  1  close-motor command from the controller.
- `obstruct`  input  1  obstacle in doorway. While high, closing motion is blocked.
- `la`  output  1  fully-open limit switch: `pos == TRAVEL_TICKS`.
- `lc`  output  1  fully-closed limit switch: `pos == 0`.
- `pos`  output  8  current door position.
- `moving`  output  1  state is OPENING or CLOSING.
- `stall`  output  1  motor commanded but no motion is possible: held against a limit, or closing while `obstruct` is high.
- `fault`  output  1  sticky flag: `ma` and `mc` were seen high together.

## Operation
- Reset values: state IDLE, `pos`=0, prescaler=0, `fault`=0. Resulting outputs: `lc`=1, `la`=0, `moving`=0, `stall`=0.
- Registers update only on edges where `ena`=1. `rst` takes priority over `ena`.
- States: IDLE, OPENING, CLOSING, FAULT (2-bit encoding).
- IDLE transitions:
  - `ma&mc` -> FAULT.
  - `ma&~mc&~la` -> OPENING.
  - `mc&~ma&~lc&~obstruct` -> CLOSING.
  - Otherwise stay in IDLE.
- OPENING transitions:
  - `ma&mc` -> FAULT.
  - `~ma` -> IDLE; position is kept.
  - On a step, `pos`+1. If the new `pos`==`TRAVEL_TICKS`, go to IDLE.
- CLOSING transitions:
  - `ma&mc` -> FAULT.
  - `~mc` or `obstruct` -> IDLE, with no step on that edge. Obstruct has priority over a pending step.
  - On a step, `pos`-1. If the new `pos`==0, go to IDLE.
- FAULT: `fault`=1; motors are ignored and `pos` is frozen. Exit only by `rst`.
- Prescaler:
  - Clears on every state change.
  - In a moving state it counts 0..`PRESCALE`-1; a step occurs on the edge where it equals `PRESCALE`-1, and it then wraps to 0.
  - With `PRESCALE`=1, every cycle is a step.
- Direct reversal is not allowed. A switch from `ma` to `mc` passes through IDLE for at least one cycle.
- `pos` never leaves 0..`TRAVEL_TICKS`, so no wrap-around is possible.
- `stall` is combinational, evaluated in IDLE only:
  - `(ma&~mc&la)`, or
  - `(mc&~ma&(lc|obstruct))`.
- `la`, `lc`, `moving` and `fault` are decoded from registers and are glitch-free.

## Timing
- Command latency: a command sampled at edge N moves the state at edge N; `moving`=1 after edge N.
- First step occurs `PRESCALE` edges after entry. Full travel from either limit takes 1 + `TRAVEL_TICKS`×`PRESCALE` edges of continuous command.
- `la`/`lc` assert in the same cycle that `pos` reaches the limit, and the state returns to IDLE on that same edge.
- Obstruct response: high at edge N while CLOSING gives IDLE after edge N, with `pos` unchanged from edge N-1.
- `rst` while moving: on the next edge `pos`=0 (closed) and the state is IDLE, regardless of prior position.
- `ena` low for K cycles stretches all timing by exactly K edges; a partial prescale count is preserved.

## Test plan
- **Open from closed:** `TRAVEL_TICKS`=4, `PRESCALE`=2, `ma` held from edge 1.
  - `pos`=1,2,3,4 at edges 3,5,7,9.
  - `la`=1 and `moving`=0 after edge 9.
  - `stall`=1 from edge 9 while `ma` is still held.
- **Close with obstruction:** start from `pos`=4, `mc` held, `obstruct` pulsed high at the edge where `pos` would go 3->2.
  - `pos` stays 3, state IDLE.
  - After `obstruct` drops, CLOSING resumes; `pos` reaches 0 after 1 + 3×2 edges and `lc`=1.
- **Fault:** `ma`=`mc`=1 for one cycle mid-opening at `pos`=2.
  - `fault`=1; `pos` stays 2 under any further `ma`/`mc`.
  - `rst` gives `pos`=0, `fault`=0.
- **Enable gating:** `ena`=0 for 5 cycles in mid-travel.
  - `pos` and prescaler are frozen.
  - Total open time = 9 + 5 edges.
- **Command release:** `ma` dropped at `pos`=2 gives IDLE with `pos`=2. `ma` reasserted gives the next step `PRESCALE` edges after re-entry.
- **Closed-loop:** connect the door controller FSM.
  - Presence sensor high at closed: `ma` asserts, `la` is reached after 1 + `TRAVEL_TICKS`×`PRESCALE` edges, and the controller advances state.
